// File: rtl/code5421_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : code5421_serial_subtractor
// Description : Digit-serial NDIG-digit 5421 decimal subtractor, A - B formed
//               as A + 9's-complement(B) + 1, one digit per clock, LSD first.
// Revision    : 1.0 - initial release
// ============================================================================
module code5421_serial_subtractor #(
  parameter int NDIG = 4
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              start,
  input  logic [4*NDIG-1:0] a_in,
  input  logic [4*NDIG-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] diff,
  output logic              borrow,
  output logic              code_err
);

  localparam int c_idx_w = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [4*NDIG-1:0]   r_a;
  logic [4*NDIG-1:0]   r_b;
  logic [4*NDIG-1:0]   r_result;
  logic [c_idx_w-1:0]  r_idx;
  logic                r_carry;
  logic                r_err;
  logic [4*NDIG-1:0]   r_diff;
  logic                r_borrow;
  logic                r_code_err;

  logic [3:0]          w_a_val;
  logic [3:0]          w_b_val;
  logic                w_dig_err;
  logic [4:0]          w_sum;
  logic                w_ge10;
  logic [3:0]          w_digit;
  logic [3:0]          w_digit_code;
  logic [4*NDIG-1:0]   w_result_next;

  // Only 0xxx with xxx<=4 and 1000..1100 are legal codes.
  function automatic logic code_ok(input logic [3:0] c);
    return !(c[2] && (c[1:0] != 2'b00));
  endfunction

  function automatic logic [3:0] code_val(input logic [3:0] c);
    logic [3:0] v;
    v = 4'd0;
    if (code_ok(c))
      v = c[3] ? ({1'b0, c[2:0]} + 4'd5) : {1'b0, c[2:0]};
    return v;
  endfunction

  function automatic logic [3:0] val_code(input logic [3:0] v);
    return (v >= 4'd5) ? (v + 4'd3) : v;
  endfunction

  // Operands shift right each RUN cycle, so the current digit is always [3:0].
  always_comb begin
    w_a_val       = code_val(r_a[3:0]);
    w_b_val       = code_val(r_b[3:0]);
    w_dig_err     = !code_ok(r_a[3:0]) || !code_ok(r_b[3:0]);
    w_sum         = {1'b0, w_a_val} + {1'b0, 4'd9 - w_b_val} + {4'd0, r_carry};
    w_ge10        = (w_sum >= 5'd10);
    w_digit       = w_ge10 ? 4'(w_sum - 5'd10) : w_sum[3:0];
    w_digit_code  = val_code(w_digit);
    w_result_next = {w_digit_code, r_result[4*NDIG-1:4]};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_idx == c_last_idx) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_code_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 4;
          r_b      <= r_b >> 4;
          r_result <= w_result_next;
          r_idx    <= r_idx + c_idx_w'(1);
          r_carry  <= w_ge10;
          r_err    <= r_err | w_dig_err;
          if (r_idx == c_last_idx) begin
            r_diff     <= w_result_next;
            r_borrow   <= ~w_ge10;
            r_code_err <= r_err | w_dig_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign code_err = r_code_err;

endmodule
`default_nettype wire
